// File: rtl/lc3b_types.sv
// Types shared by the LC-3b pipeline control blocks: register specifier and the
// MEM-stage data-memory sequencer states.
package lc3b_types;

    localparam int LC3B_REG_W = 3;

    typedef logic [LC3B_REG_W-1:0] lc3b_reg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ACC,
        M_IND1,
        M_IND2
    } lc3b_memfsm_t;

endpackage

// File: rtl/pipe_stall_ctrl_loaduse.sv
// Load-use hazard compare: an in-flight load in EX writes a register that the
// ID instruction actually reads, so forwarding cannot supply it in time.
module loaduse_detect
    import lc3b_types::*;
#(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_sr1_used,
    input  logic             id_sr2_used,
    input  logic [REG_W-1:0] ex_dr,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_regwrite,
    output logic             hazard
);

    logic sr1_hit;
    logic sr2_hit;

    assign sr1_hit = id_sr1_used & (id_sr1 == ex_dr);
    assign sr2_hit = id_sr2_used & (id_sr2 == ex_dr);
    assign hazard  = ex_valid & ex_is_load & ex_regwrite & (sr1_hit | sr2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipe: load-use bubbles, branch
// flushes, cache-miss freezes, MEM-stage dmem sequencing and a stall counter.
module pipe_stall_ctrl
    import lc3b_types::*;
#(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_sr1_used,
    input  logic             id_sr2_used,
    input  logic [REG_W-1:0] ex_dr,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_regwrite,
    input  logic             imem_resp,
    input  logic             mem_rd_req,
    input  logic             mem_wr_req,
    input  logic             mem_indirect,
    input  logic             dmem_resp,
    input  logic             br_taken_mem,
    input  logic             stat_clr,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             ind_phase,
    output logic             ind_ptr_load,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_count
);

    lc3b_memfsm_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req, final_acc, dfreeze, freeze, hazard;
    logic             rd_s, wr_s, ph_s, ptr_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    loaduse_detect #(.REG_W(REG_W)) u_loaduse (
        .id_sr1      (id_sr1),
        .id_sr2      (id_sr2),
        .id_sr1_used (id_sr1_used),
        .id_sr2_used (id_sr2_used),
        .ex_dr       (ex_dr),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_regwrite (ex_regwrite),
        .hazard      (hazard)
    );

    assign mem_req = mem_rd_req | mem_wr_req;

    // Strobes go out in the detecting M_IDLE cycle; a response there is stale and ignored.
    always_comb begin
        state_d   = state_q;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        ph_s      = 1'b0;
        ptr_s     = 1'b0;
        final_acc = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (mem_req) begin
                    if (mem_indirect) begin
                        rd_s    = 1'b1;
                        state_d = M_IND1;
                    end else begin
                        rd_s    = mem_rd_req;
                        wr_s    = mem_wr_req;
                        state_d = M_ACC;
                    end
                end
            end
            M_ACC: begin
                rd_s      = mem_rd_req;
                wr_s      = mem_wr_req;
                final_acc = 1'b1;
                if (dmem_resp) state_d = M_IDLE;
            end
            M_IND1: begin
                rd_s = 1'b1;
                if (dmem_resp) begin
                    ptr_s   = 1'b1;
                    state_d = M_IND2;
                end
            end
            M_IND2: begin
                ph_s      = 1'b1;
                rd_s      = mem_rd_req;
                wr_s      = mem_wr_req;
                final_acc = 1'b1;
                if (dmem_resp) state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    assign dfreeze = mem_req & ~(dmem_resp & final_acc);
    assign freeze  = dfreeze | ~imem_resp;

    always_comb begin
        dmem_read    = rd_s & ~reset;
        dmem_write   = wr_s & ~reset;
        ind_phase    = ph_s & ~reset;
        ind_ptr_load = ptr_s & ~reset;
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (!reset && !freeze) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (br_taken_mem) begin
                load_pc      = 1'b1;
                load_if_id   = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (hazard) begin
                bubble_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr)                    cnt_d = '0;
        else if (freeze || bubble_id_ex) cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed hazard/miss/indirect/flush
// sequences followed by constrained-random traffic against a transaction-level model.
module tb_pipe_stall_ctrl;

    localparam int REG_W = 3;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [REG_W-1:0] id_sr1, id_sr2, ex_dr;
    logic             id_sr1_used, id_sr2_used, ex_valid, ex_is_load, ex_regwrite;
    logic             imem_resp, mem_rd_req, mem_wr_req, mem_indirect, dmem_resp;
    logic             br_taken_mem, stat_clr;
    logic             dmem_read, dmem_write, ind_phase, ind_ptr_load;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic [CNT_W-1:0] stall_count;

    pipe_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
        .ex_dr(ex_dr), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite),
        .imem_resp(imem_resp), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_indirect(mem_indirect), .dmem_resp(dmem_resp), .br_taken_mem(br_taken_mem),
        .stat_clr(stat_clr), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .ind_phase(ind_phase), .ind_ptr_load(ind_ptr_load), .load_pc(load_pc),
        .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
        .load_mem_wb(load_mem_wb), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .stall_count(stall_count)
    );

    typedef struct packed {
        logic [12:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    // Model: accesses still owed by the current memory instruction (0 = none in flight).
    int m_left = 0;
    bit m_ind  = 1'b0;
    int m_cnt  = 0;

    task automatic clr_inputs();
        reset = 1'b0; id_sr1 = '0; id_sr2 = '0; ex_dr = '0;
        id_sr1_used = 1'b0; id_sr2_used = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        ex_regwrite = 1'b0; imem_resp = 1'b1; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
        mem_indirect = 1'b0; dmem_resp = 1'b0; br_taken_mem = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic step();
        logic rd, wr, ph, ptr, lpc, lifid, lidex, lexmem, lmemwb, bub, fl;
        logic req, dfz, frz, haz;
        exp_t e;
        {rd, wr, ph, ptr, lpc, lifid, lidex, lexmem, lmemwb, bub, fl} = '0;
        frz = 1'b0;
        req = mem_rd_req | mem_wr_req;
        if (!reset) begin
            if (m_left == 0) begin
                if (req) begin
                    rd = mem_indirect ? 1'b1 : mem_rd_req;
                    wr = mem_indirect ? 1'b0 : mem_wr_req;
                end
            end else if (m_left == 2) begin
                rd  = 1'b1;
                ptr = dmem_resp;
            end else begin
                rd = mem_rd_req;
                wr = mem_wr_req;
                ph = m_ind;
            end
            dfz = req && !(m_left == 1 && dmem_resp);
            frz = dfz || !imem_resp;
            haz = ex_valid && ex_is_load && ex_regwrite &&
                  ((id_sr1_used && id_sr1 == ex_dr) || (id_sr2_used && id_sr2 == ex_dr));
            if (!frz) begin
                {lpc, lifid, lidex, lexmem, lmemwb} = 5'b11111;
                if (br_taken_mem) fl = 1'b1;
                else if (haz) begin
                    lpc = 1'b0; lifid = 1'b0; bub = 1'b1;
                end
            end
        end
        e.ctrl = {rd, wr, ph, ptr, lpc, lifid, lidex, lexmem, lmemwb, bub, fl, fl, fl};
        e.cnt  = m_cnt[CNT_W-1:0];
        q.push_back(e);
        if (reset) begin
            m_left = 0;
            m_cnt  = 0;
        end else begin
            if (stat_clr) m_cnt = 0;
            else if ((frz || bub) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_left == 0 && req) begin
                m_left = mem_indirect ? 2 : 1;
                m_ind  = mem_indirect;
            end else if (m_left > 0 && dmem_resp) begin
                m_left--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        int r;
        reset        = ($urandom_range(0, 99) < 2);
        imem_resp    = ($urandom_range(0, 99) < 80);
        br_taken_mem = ($urandom_range(0, 99) < 15);
        id_sr1       = REG_W'($urandom_range(0, 3));
        id_sr2       = REG_W'($urandom_range(0, 3));
        ex_dr        = REG_W'($urandom_range(0, 3));
        id_sr1_used  = ($urandom_range(0, 99) < 70);
        id_sr2_used  = ($urandom_range(0, 99) < 50);
        ex_valid     = ($urandom_range(0, 99) < 80);
        ex_is_load   = ($urandom_range(0, 99) < 60);
        ex_regwrite  = ($urandom_range(0, 99) < 80);
        stat_clr     = ($urandom_range(0, 99) < 4);
        dmem_resp    = ($urandom_range(0, 99) < 35);
        if (m_left == 0) begin
            r = $urandom_range(0, 9);
            mem_rd_req   = (r == 0 || r == 1 || r == 3);
            mem_wr_req   = (r == 2 || r == 4);
            mem_indirect = (r == 3 || r == 4);
        end
    endtask

    task automatic sti_prefix();
        wr_sti();
        dmem_resp = 1'b0; step();
        dmem_resp = 1'b0; step();
        dmem_resp = 1'b1; step();
        dmem_resp = 1'b0; step();
    endtask

    task automatic wr_sti();
        mem_wr_req = 1'b1; mem_indirect = 1'b1;
    endtask

    initial begin
        clr_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();

        // load-use bubble, then the load has moved on
        clr_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_dr = 3'd1;
        id_sr1 = 3'd1; id_sr1_used = 1'b1; id_sr2 = 3'd3; id_sr2_used = 1'b1;
        step();
        ex_valid = 1'b0; step();
        // match only on an unused source
        ex_valid = 1'b1; id_sr1 = 3'd2; id_sr2 = 3'd1; id_sr2_used = 1'b0;
        step();

        // plain load with a 3-cycle miss
        clr_inputs();
        mem_rd_req = 1'b1;
        repeat (3) step();
        dmem_resp = 1'b1; step();
        clr_inputs(); step();

        // STI with two slow accesses
        sti_prefix();
        dmem_resp = 1'b1; step();
        clr_inputs(); step();

        // taken branch held behind an icache miss, with a load-use hazard present
        clr_inputs();
        br_taken_mem = 1'b1; imem_resp = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_dr = 3'd2;
        id_sr1 = 3'd2; id_sr1_used = 1'b1;
        repeat (2) step();
        imem_resp = 1'b1; step();
        br_taken_mem = 1'b0; ex_valid = 1'b0; step();

        // long icache miss drives the counter into saturation, then clear
        clr_inputs();
        imem_resp = 1'b0;
        repeat (20) step();
        imem_resp = 1'b1; stat_clr = 1'b1; step();
        stat_clr = 1'b0; step();

        // reset while the second indirect access is outstanding
        clr_inputs();
        sti_prefix();
        reset = 1'b1; step();
        clr_inputs(); step();

        repeat (3000) begin
            rand_inputs();
            step();
        end
        stim_done = 1'b1;
    end

    initial begin
        exp_t e;
        logic [12:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {dmem_read, dmem_write, ind_phase, ind_ptr_load, load_pc, load_if_id,
                       load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id,
                       flush_id_ex, flush_ex_mem};
                n_vec++;
                if (act !== e.ctrl) begin
                    n_err++;
                    $display("FAIL ctrl @%0t: got %b, required %b", $time, act, e.ctrl);
                end
                n_vec++;
                if (stall_count !== e.cnt) begin
                    n_err++;
                    $display("FAIL stall_count @%0t: got %0d, required %0d",
                             $time, stall_count, e.cnt);
                end
            end else if (stim_done) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares",
                 n_vec, n_err);
        $fatal(1);
    end

endmodule
